// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit and the mdctrl decoder.
// Holds the MDU_Op encodings, the default latencies and the FSM state type.
package mdu_pkg;

    localparam logic [1:0] MDU_DIV   = 2'b11;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_MULTU = 2'b00;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: owns HI/LO and runs multi-cycle mult/div/madd.
// Results are computed at launch into shadow registers and committed after the latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [1:0]  MDU_Op,
    input  logic        Add,
    input  logic        HiLo,
    input  logic        WriteEnabled,
    output logic        Busy,
    output logic [31:0] Out
);

    mdu_state_t  state;
    logic [15:0] count;
    logic [31:0] hi, lo;
    logic [31:0] res_hi, res_lo;
    logic        res_commit;

    logic        signed_div;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [63:0] a_sext, b_sext, prod_s, prod_u, madd_sum;
    logic [31:0] launch_hi, launch_lo;
    logic        launch_commit;
    logic [15:0] launch_count;

    // Signed division works on magnitudes so 0x80000000 / -1 falls out naturally.
    always_comb begin
        signed_div = (MDU_Op == MDU_DIV);
        a_neg      = signed_div & A[31];
        b_neg      = signed_div & B[31];
        a_mag      = a_neg ? -A : A;
        b_mag      = b_neg ? -B : B;
        q_mag      = '0;
        r_mag      = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem  = a_neg ? -r_mag : r_mag;

        a_sext   = {{32{A[31]}}, A};
        b_sext   = {{32{B[31]}}, B};
        prod_s   = a_sext * b_sext;
        prod_u   = {32'd0, A} * {32'd0, B};
        madd_sum = {hi, lo} + prod_s;

        launch_commit = 1'b1;
        launch_count  = 16'(MUL_CYCLES);
        launch_hi     = madd_sum[63:32];
        launch_lo     = madd_sum[31:0];
        if (Start) begin
            case (MDU_Op)
                MDU_DIV, MDU_DIVU: begin
                    launch_hi     = rem;
                    launch_lo     = quot;
                    launch_commit = (B != 32'd0);
                    launch_count  = 16'(DIV_CYCLES);
                end
                MDU_MULT: begin
                    launch_hi = prod_s[63:32];
                    launch_lo = prod_s[31:0];
                end
                default: begin
                    launch_hi = prod_u[63:32];
                    launch_lo = prod_u[31:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            res_hi     <= '0;
            res_lo     <= '0;
            res_commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start || Add) begin
                        res_hi     <= launch_hi;
                        res_lo     <= launch_lo;
                        res_commit <= launch_commit;
                        count      <= launch_count;
                        state      <= RUN;
                        Busy       <= 1'b1;
                    end else if (WriteEnabled) begin
                        if (HiLo) lo <= A;
                        else      hi <= A;
                    end
                end
                RUN: begin
                    // Divide-by-zero still burns the full latency but skips the commit.
                    if (count <= 16'd1) begin
                        if (res_commit) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        count <= '0;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        count <= count - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Out = HiLo ? lo : hi;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: arithmetic results, busy latency,
// ignored inputs while running and reset mid-operation.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic        Start, Add, HiLo, WriteEnabled;
    logic [1:0]  MDU_Op;
    logic        Busy;
    logic [31:0] Out;

    int tests = 0;
    int fails = 0;

    mdu dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Start(Start), .MDU_Op(MDU_Op),
        .Add(Add), .HiLo(HiLo), .WriteEnabled(WriteEnabled), .Busy(Busy), .Out(Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        HiLo = 1'b0;
        #1;
        check({tag, "_hi"}, Out, exp_hi);
        HiLo = 1'b1;
        #1;
        check({tag, "_lo"}, Out, exp_lo);
    endtask

    // Drives one launch cycle; returns at the negedge of the first busy cycle.
    task automatic applyStimulus(input logic st, input logic [1:0] op, input logic ad,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = st; MDU_Op = op; Add = ad; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; Add = 1'b0;
    endtask

    task automatic writeReg(input logic sel, input logic [31:0] data);
        @(negedge clk);
        WriteEnabled = 1'b1; HiLo = sel; A = data;
        @(negedge clk);
        WriteEnabled = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int exp_cycles);
        int n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        reset = 1'b1; A = '0; B = '0; Start = 1'b0; Add = 1'b0;
        HiLo = 1'b0; WriteEnabled = 1'b0; MDU_Op = MDU_MULTU;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset", 32'h0, 32'h0);
        reset = 1'b0;

        applyStimulus(1'b1, MDU_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3);
        waitIdle("mult_busy", 5);
        checkOutput("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        applyStimulus(1'b1, MDU_MULTU, 1'b0, 32'hFFFF_FFFE, 32'd3);
        waitIdle("multu_busy", 5);
        checkOutput("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        applyStimulus(1'b1, MDU_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2);
        waitIdle("div_busy", 10);
        checkOutput("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        applyStimulus(1'b1, MDU_DIVU, 1'b0, 32'd7, 32'd0);
        waitIdle("divu0_busy", 10);
        checkOutput("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        applyStimulus(1'b1, MDU_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle("divovf_busy", 10);
        checkOutput("divovf", 32'h0, 32'h8000_0000);

        applyStimulus(1'b1, MDU_DIVU, 1'b0, 32'd100, 32'd7);
        waitIdle("divu_busy", 10);
        checkOutput("divu", 32'd2, 32'd14);

        writeReg(1'b1, 32'd5);
        checkOutput("mtlo", 32'd2, 32'd5);
        writeReg(1'b0, 32'd0);
        checkOutput("mthi", 32'd0, 32'd5);
        applyStimulus(1'b0, MDU_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd1);
        waitIdle("madd_busy", 5);
        checkOutput("madd", 32'd0, 32'd4);

        applyStimulus(1'b1, MDU_MULTU, 1'b1, 32'd2, 32'd3);
        waitIdle("prio_busy", 5);
        checkOutput("prio", 32'd0, 32'd6);

        applyStimulus(1'b1, MDU_MULT, 1'b0, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        Start = 1'b1; MDU_Op = MDU_MULTU; A = 32'h1234; B = 32'd1;
        WriteEnabled = 1'b1; HiLo = 1'b0;
        @(negedge clk);
        Start = 1'b0; WriteEnabled = 1'b0;
        check("ign_busy_mid", {31'd0, Busy}, 32'd1);
        checkOutput("ign_mid", 32'd0, 32'd6);
        waitIdle("ign_busy_rest", 3);
        checkOutput("ign", 32'd1, 32'd0);

        writeReg(1'b1, 32'h55);
        applyStimulus(1'b1, MDU_DIV, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst", 32'd0, 32'd0);

        applyStimulus(1'b1, MDU_MULT, 1'b0, 32'd7, 32'd6);
        waitIdle("post_rst_busy", 5);
        checkOutput("post_rst", 32'd0, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage, on the receiving end of the `mdctrl` decode signals. It owns the HI and LO registers and runs multi-cycle `mult`, `multu`, `div`, `divu` and `madd` operations. It also serves `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. `Busy` tells the hazard unit to stall any following MD-class instruction.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for `mult`, `multu` and `madd`.
- `DIV_CYCLES`, default 10: busy cycles for `div` and `divu`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `A` in 32: rs operand, also the source data for `mthi`/`mtlo`.
- `B` in 32: rt operand.
- `Start` in 1: launch mult/div; the operation is selected by `MDU_Op`.
- `MDU_Op` in 2: 11 `div`, 10 `divu`, 01 `mult`, 00 `multu`.
- `Add` in 1: launch signed `madd`.
- `HiLo` in 1: register select, 0 = HI, 1 = LO, for both write and read.
- `WriteEnabled` in 1: `mthi`/`mtlo` write strobe.
- `Busy` out 1: an operation is in progress.
- `Out` out 32: `HiLo ? LO : HI`, combinational read.

## Operation
- States: IDLE and RUN. A down-counter holds the cycles remaining.
- IDLE with `Start`=1:
  - Latch the operation and its result into shadow registers `res_hi`/`res_lo`. The result is computed combinationally from `A`/`B` at launch.
  - Load the counter with `MUL_CYCLES` or `DIV_CYCLES`, then go to RUN.
- IDLE with `Add`=1 and `Start`=0: launch `madd`.
  - Shadow result is `{HI,LO} + $signed(A)*$signed(B)`, 64-bit wrap, using current HI/LO.
  - Counter loads `MUL_CYCLES`.
- `Start` and `Add` both high: `Start` has priority and `Add` is ignored.
- IDLE with `WriteEnabled`=1 and no launch: write `A` into HI (`HiLo`=0) or LO (`HiLo`=1).
- RUN:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, commit the shadow result to HI/LO and return to IDLE.
- Arithmetic:
  - `mult`/`multu`: 64-bit product, signed or unsigned; HI gets the upper 32 bits, LO the lower 32.
  - `div`/`divu`: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero (`B`=0): run the full `DIV_CYCLES`, but HI/LO are left unchanged (no commit).
  - `div` of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- `Start`, `Add` and `WriteEnabled` are ignored while `Busy`=1. The pipeline stalls them, so any assertion here is a stimulus error.
- `Out` is readable in any state and shows committed HI/LO only, never the shadow registers.

## Timing
- Reset values: HI=0, LO=0, `Busy`=0, state IDLE, counter 0, shadow registers 0.
- Launch in cycle T:
  - `Busy`=1 in cycles T+1 through T+N, where N is the cycle parameter.
  - HI/LO are committed at the clock edge ending T+N, so new values appear on `Out` in T+N+1.
  - `Busy`=0 from T+N+1.
- Back-to-back: a new launch is accepted in cycle T+N+1.
- `mthi`/`mtlo` in cycle T: the value is visible on `Out` in T+1.
- Reset mid-operation: the next cycle has `Busy`=0 and HI=LO=0; the in-flight result is discarded.
- `Busy` is registered; it has no combinational path from inputs.

## Structure
- Shared package `mdu_pkg` holds:
  - `MDU_Op` encodings (`MDU_DIV`, `MDU_DIVU`, `MDU_MULT`, `MDU_MULTU`);
  - default latencies `MUL_CYCLES`=5, `DIV_CYCLES`=10;
  - the IDLE/RUN state encoding.
- The `mdctrl` decoder uses the same package constants.
- No sub-module. The arithmetic is behavioural operators inside `mdu`.

## Test plan
- `mult` with `A`=0xFFFFFFFE, `B`=3:
  - `Busy` high for exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- `multu` with `A`=0xFFFFFFFE, `B`=3: HI=0x00000002, LO=0xFFFFFFFA.
- Division:
  - `div` with `A`=0xFFFFFFF9, `B`=2: `Busy` high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `divu` with `A`=7, `B`=0: `Busy` high for 10 cycles, and HI/LO keep their prior values.
- `madd`:
  - `mtlo` 5 and `mthi` 0, then `Add` with `A`=0xFFFFFFFF, `B`=1.
  - Expected after 5 busy cycles: HI=0, LO=4.
  - `HiLo` toggling reads each register on `Out`.
- Ignored inputs during RUN: launch `mult`, then pulse `Start` and `mthi` with `A`=0x1234 during cycle 2 of RUN.
  - Both are ignored, `Busy` still ends after cycle 5, and HI holds the product.
- Reset mid-operation: assert `reset` in cycle 3 of a `div`.
  - Next cycle: `Busy`=0, HI=LO=0.
  - A new `mult` launched right after reset completes normally.
